// File: rtl/uart_prog_ctrl_pkg.sv
// uart_prog_pkg: shared types and constants for the UART programming sequencer.
//   - prog_state_e : sequencer state encoding (ST_CSUM exists only when
//                    CHECKSUM_EN is defined)
//   - HDR_BYTES, BYTES_PER_WORD : framing constants
//   - tmo_width()  : width of a counter that must be able to hold TIMEOUT
// Optional feature macro: CHECKSUM_EN
package uart_prog_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_WRITE,
`ifdef CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERR
    } prog_state_e;

    function automatic int tmo_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/uart_prog_ctrl_word_pack.sv
// word_pack: little-endian byte-to-word assembler.
//   clk, rst        : clock, async active-low reset
//   clr_i           : synchronous clear of lane counter and partial word
//   byte_valid_i    : byte_i is to be stored into the current lane
//   byte_i          : incoming byte
//   word_valid_o    : combinational pulse, the byte being stored completes a word
//   word_o          : assembled word including the byte currently presented
module word_pack
    import uart_prog_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       word_asm;

    always_comb begin
        word_asm = word_q;
        word_asm[{lane_q, 3'b000} +: 8] = byte_i;

        lane_d = lane_q;
        word_d = word_q;
        if (clr_i) begin
            lane_d = '0;
            word_d = '0;
        end else if (byte_valid_i) begin
            // lane counter wraps to 0 after the top lane
            lane_d = lane_q + LANE_W'(1);
            word_d = word_asm;
        end
    end

    assign word_o       = word_asm;
    assign word_valid_o = byte_valid_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/uart_prog_ctrl.sv
// uart_prog_ctrl: UART programming sequencer. Reads a 16-bit little-endian
// word count, packs the following bytes into 32-bit words and writes them to
// memory, holding the CPU in reset for the whole upload.
//   clk, rst       : clock, async active-low reset
//   start_i        : begin an upload (ignored while busy)
//   rx_valid_i/rx_byte_i : received byte strobe and data
//   upg_wen_o/upg_adr_o/upg_dat_o : memory write port (one pulse per word)
//   upg_done_o     : memory owned by the CPU
//   cpu_rst_n_o    : active-low CPU reset request
//   busy_o, err_o  : upload in progress / last upload failed
// Optional feature macro: CHECKSUM_EN (trailing XOR byte after the data)
//
// state | meaning
// IDLE  | CPU running, waiting for start
// HDR0  | waiting for word count low byte
// HDR1  | waiting for word count high byte
// DATA  | collecting bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// CSUM  | waiting for the XOR checksum byte (CHECKSUM_EN only)
// DONE  | one cycle: memory released, CPU still in reset
// ERR   | upload failed, CPU held, wait for start
module uart_prog_ctrl
    import uart_prog_pkg::*;
#(
    parameter int ADR_W     = 15,
    parameter int MAX_WORDS = 32768,
    parameter int TIMEOUT   = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_byte_i,
    output logic             upg_wen_o,
    output logic [ADR_W-1:0] upg_adr_o,
    output logic [31:0]      upg_dat_o,
    output logic             upg_done_o,
    output logic             cpu_rst_n_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int TMO_W = tmo_width(TIMEOUT);

    prog_state_e      state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
`ifdef CHECKSUM_EN
    logic [7:0]       xor_q, xor_d;
`endif

    logic        pack_clr, pack_byte, word_valid;
    logic [31:0] word;
    logic [15:0] cnt_new;
    logic        tmo_expired, last_word;

    word_pack u_word_pack (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (pack_clr),
        .byte_valid_i (pack_byte),
        .byte_i       (rx_byte_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    assign cnt_new     = {rx_byte_i, cnt_q[7:0]};
    // the cycle in which the counter would reach TIMEOUT goes to ERR
    assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign last_word   = ((idx_q + 16'd1) == cnt_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        pack_clr  = 1'b0;
        pack_byte = 1'b0;
`ifdef CHECKSUM_EN
        xor_d     = xor_q;
`endif
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start_i) begin
                    state_d  = ST_HDR0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    tmo_d    = '0;
                    pack_clr = 1'b1;
`ifdef CHECKSUM_EN
                    xor_d    = '0;
`endif
                end
            end
            ST_HDR0: begin
                if (rx_valid_i) begin
                    cnt_d[7:0] = rx_byte_i;
                    tmo_d      = '0;
                    state_d    = ST_HDR1;
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_HDR1: begin
                if (rx_valid_i) begin
                    cnt_d = cnt_new;
                    tmo_d = '0;
                    if (cnt_new == 16'd0)
                        state_d = ST_DONE;
                    else if ({16'd0, cnt_new} > 32'(MAX_WORDS))
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DATA: begin
                if (rx_valid_i) begin
                    pack_byte = 1'b1;
                    tmo_d     = '0;
`ifdef CHECKSUM_EN
                    xor_d     = xor_q ^ rx_byte_i;
`endif
                    if (word_valid) begin
                        state_d = ST_WRITE;
                        adr_d   = ADR_W'(idx_q);
                        dat_d   = word;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WRITE: begin
                idx_d = idx_q + 16'd1;
                if (last_word) begin
`ifdef CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DATA;
                    // lane counter is back at 0, so this byte starts the next word
                    if (rx_valid_i) begin
                        pack_byte = 1'b1;
                        tmo_d     = '0;
`ifdef CHECKSUM_EN
                        xor_d     = xor_q ^ rx_byte_i;
`endif
                    end
                end
            end
`ifdef CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid_i) begin
                    tmo_d   = '0;
                    state_d = (rx_byte_i == xor_q) ? ST_DONE : ST_ERR;
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
`ifdef CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
`ifdef CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign upg_wen_o   = (state_q == ST_WRITE);
    assign upg_adr_o   = adr_q;
    assign upg_dat_o   = dat_q;
    assign upg_done_o  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign cpu_rst_n_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign err_o       = (state_q == ST_ERR);

endmodule

// File: tb/tb_uart_prog_ctrl.sv
module tb_uart_prog_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        rx_valid_i;
    logic [7:0]  rx_byte_i;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        cpu_rst_n_o;
    logic        busy_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int wen_cnt = 0;
    int wen_base;

    uart_prog_ctrl #(
        .ADR_W     (15),
        .MAX_WORDS (32768),
        .TIMEOUT   (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .rx_valid_i  (rx_valid_i),
        .rx_byte_i   (rx_byte_i),
        .upg_wen_o   (upg_wen_o),
        .upg_adr_o   (upg_adr_o),
        .upg_dat_o   (upg_dat_o),
        .upg_done_o  (upg_done_o),
        .cpu_rst_n_o (cpu_rst_n_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // write pulses are counted mid-cycle, away from the active edge
    always @(negedge clk)
        if (upg_wen_o === 1'b1) wen_cnt <= wen_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_byte_i  = b;
        tick();
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'h00;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'h00;
        tick();
        tick();
        chk("rst_wen",   32'(upg_wen_o),   32'd0);
        chk("rst_adr",   32'(upg_adr_o),   32'd0);
        chk("rst_dat",   upg_dat_o,        32'd0);
        chk("rst_done",  32'(upg_done_o),  32'd1);
        chk("rst_cpurn", 32'(cpu_rst_n_o), 32'd1);
        chk("rst_busy",  32'(busy_o),      32'd0);
        chk("rst_err",   32'(err_o),       32'd0);
        rst = 1'b1;
        tick();

        // two-word upload, second word's first byte lands during WRITE
        wen_base = wen_cnt;
        do_start();
        chk("hdr0_busy",  32'(busy_o),      32'd1);
        chk("hdr0_done",  32'(upg_done_o),  32'd0);
        chk("hdr0_cpurn", 32'(cpu_rst_n_o), 32'd0);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        chk("w0_wen", 32'(upg_wen_o), 32'd1);
        chk("w0_adr", 32'(upg_adr_o), 32'd0);
        chk("w0_dat", upg_dat_o,      32'h12345678);
        send_byte(8'hEF);
        chk("w0_wen_low", 32'(upg_wen_o), 32'd0);
        chk("w0_adr_hold", 32'(upg_adr_o), 32'd0);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        chk("w1_wen", 32'(upg_wen_o), 32'd1);
        chk("w1_adr", 32'(upg_adr_o), 32'd1);
        chk("w1_dat", upg_dat_o,      32'hDEADBEEF);
`ifdef CHECKSUM_EN
        tick();
        send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`else
        tick();
`endif
        chk("two_done_done",  32'(upg_done_o),  32'd1);
        chk("two_done_cpurn", 32'(cpu_rst_n_o), 32'd0);
        chk("two_done_busy",  32'(busy_o),      32'd1);
        tick();
        chk("two_idle_cpurn", 32'(cpu_rst_n_o), 32'd1);
        chk("two_idle_busy",  32'(busy_o),      32'd0);
        chk("two_wen_count",  32'(wen_cnt - wen_base), 32'd2);

        // zero word count
        wen_base = wen_cnt;
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("zero_done",  32'(upg_done_o),  32'd1);
        chk("zero_cpurn", 32'(cpu_rst_n_o), 32'd0);
        tick();
        chk("zero_idle",  32'(cpu_rst_n_o), 32'd1);
        chk("zero_wen_count", 32'(wen_cnt - wen_base), 32'd0);

        // oversize word count 0x8001
        wen_base = wen_cnt;
        do_start();
        send_byte(8'h01);
        send_byte(8'h80);
        chk("over_err",   32'(err_o),       32'd1);
        chk("over_cpurn", 32'(cpu_rst_n_o), 32'd0);
        chk("over_done",  32'(upg_done_o),  32'd0);
        chk("over_busy",  32'(busy_o),      32'd0);
        send_byte(8'h55);
        chk("over_rx_ignored", 32'(err_o), 32'd1);
        chk("over_wen_count", 32'(wen_cnt - wen_base), 32'd0);
        do_start();
        chk("over_restart_err",  32'(err_o),  32'd0);
        chk("over_restart_busy", 32'(busy_o), 32'd1);

        // timeout: already in HDR0 from the restart
        wen_base = wen_cnt;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hA0);
        send_byte(8'hA1);
        repeat (99) tick();
        chk("tmo_99_err", 32'(err_o), 32'd0);
        tick();
        chk("tmo_100_err",   32'(err_o),       32'd1);
        chk("tmo_100_cpurn", 32'(cpu_rst_n_o), 32'd0);
        chk("tmo_wen_count", 32'(wen_cnt - wen_base), 32'd0);

        // a byte arriving on the timeout cycle wins, and restarts the count
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (99) tick();
        send_byte(8'h33);
        chk("tmo_save_err", 32'(err_o), 32'd0);
        repeat (99) tick();
        send_byte(8'h44);
        chk("tmo_save_wen", 32'(upg_wen_o), 32'd1);
        chk("tmo_save_dat", upg_dat_o,      32'h44332211);
        tick();
`ifdef CHECKSUM_EN
        send_byte(8'h44);
`endif
        chk("tmo_save_done", 32'(upg_done_o), 32'd1);
        tick();

        // asynchronous reset in the middle of DATA
        do_start();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy",  32'(busy_o),      32'd0);
        chk("arst_done",  32'(upg_done_o),  32'd1);
        chk("arst_cpurn", 32'(cpu_rst_n_o), 32'd1);
        chk("arst_dat",   upg_dat_o,        32'd0);
        chk("arst_adr",   32'(upg_adr_o),   32'd0);
        tick();
        rst = 1'b1;
        tick();

        // clean upload after reset, lanes start from 0
        wen_base = wen_cnt;
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        chk("clean_wen", 32'(upg_wen_o), 32'd1);
        chk("clean_adr", 32'(upg_adr_o), 32'd0);
        chk("clean_dat", upg_dat_o,      32'h04030201);
        tick();
`ifdef CHECKSUM_EN
        chk("csum_wait_busy", 32'(busy_o), 32'd1);
        send_byte(8'h04);
`endif
        chk("clean_done", 32'(upg_done_o), 32'd1);
        tick();
        chk("clean_idle", 32'(cpu_rst_n_o), 32'd1);

`ifdef CHECKSUM_EN
        // wrong checksum: write kept, upload fails
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        chk("bad_csum_wen", 32'(upg_wen_o), 32'd1);
        tick();
        send_byte(8'h05);
        chk("bad_csum_err",  32'(err_o),      32'd1);
        chk("bad_csum_done", 32'(upg_done_o), 32'd0);
        chk("bad_csum_wens", 32'(wen_cnt - wen_base), 32'd2);
`else
        chk("clean_wen_count", 32'(wen_cnt - wen_base), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_prog_ctrl.md
Name: uart_prog_ctrl

Overview:
Sequencer for the UART programming path. It takes bytes from the UART receiver, reads a word-count header, packs little-endian bytes into 32-bit words, and drives the upg_wen/upg_adr/upg_dat/upg_done inputs of the memory block. It holds the CPU in reset while an upload runs. It sits between the UART RX and memory/IFetch in cpu_top, and replaces the tied-off upg_done_i = 1.

Parameters:
- ADR_W, 15, width of upg_adr_o (word address).
- MAX_WORDS, 32768, largest accepted word count; must be ≤ 2^ADR_W.
- TIMEOUT, 1000000, idle clk cycles allowed between accepted bytes before abort; must be ≥ 1.

Ports:
- clk  in  1  system clock (the same clock that feeds memory).
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle synchronous request to begin an upload.
- rx_valid_i  in  1  one-cycle strobe: rx_byte_i is valid.
- rx_byte_i  in  8  received byte.
- upg_wen_o  out  1  memory write enable, one-cycle pulse per word.
- upg_adr_o  out  ADR_W  word address of the current write.
- upg_dat_o  out  32  word being written.
- upg_done_o  out  1  1 = memory owned by the CPU; 0 = upload in progress or failed.
- cpu_rst_n_o  out  1  active-low CPU reset request.
- busy_o  out  1  upload in progress.
- err_o  out  1  last upload failed (header, timeout or checksum).

Behaviour:
- Reset values: state IDLE; upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=1, cpu_rst_n_o=1, busy_o=0, err_o=0. All internal counters are 0.
- Reset can assert at any point, including mid-upload. It returns to IDLE with the reset values above and does not roll back writes already made.
- States: IDLE, HDR0, HDR1, DATA, WRITE, [CSUM], DONE, ERR.
- IDLE, and ERR: start_i moves to HDR0. On entry to HDR0: upg_done_o=0, cpu_rst_n_o=0, busy_o=1, err_o=0; word index, byte lane and timeout counter cleared.
- While busy_o=1, start_i is ignored.
- HDR0: a byte on rx_valid_i becomes cnt[7:0]; go to HDR1.
- HDR1: a byte becomes cnt[15:8], then:
  - cnt==0 → DONE;
  - cnt>MAX_WORDS → ERR;
  - otherwise → DATA.
- DATA: each byte goes into lane L (bits 8L+7:8L), and L increments. Lane 3 completes a word: the next cycle is WRITE.
- WRITE (exactly 1 cycle):
  - upg_wen_o=1, upg_adr_o=index[ADR_W-1:0], upg_dat_o=assembled word; then index++.
  - If index+1==cnt → CSUM when CHECKSUM_EN is defined, otherwise DONE. Else → DATA.
  - A byte arriving during WRITE is accepted into lane 0 when more words remain; it is dropped after the last word.
- upg_adr_o and upg_dat_o hold their last values outside WRITE. upg_wen_o is 0 in every state except WRITE.
- Timeout:
  - In HDR0, HDR1, DATA and CSUM, a counter increments every cycle and clears on each accepted byte.
  - When it reaches TIMEOUT, the next state is ERR.
  - A byte arriving in the same cycle takes priority over the timeout.
- DONE (1 cycle): upg_done_o=1, cpu_rst_n_o still 0. Next cycle → IDLE with cpu_rst_n_o=1 and busy_o=0. The CPU therefore sees at least one reset cycle with upg_done_o=1.
- ERR:
  - Outputs: err_o=1, busy_o=0, upg_done_o=0, cpu_rst_n_o=0.
  - The CPU stays held, because memory is partial.
  - rx bytes are ignored. Only start_i or rst leaves this state.
- rx_valid_i while in IDLE/DONE/ERR is ignored.

Optional Feature:
CHECKSUM_EN
- Defined:
  - A running XOR of all data bytes (header excluded) is kept; it is cleared on entry to HDR0.
  - After the last word, state CSUM waits for one byte.
  - byte == XOR → DONE; mismatch → ERR. Writes already made are kept.
  - cnt==0 skips CSUM and goes directly to DONE.
- Undefined: no CSUM state, no XOR register; the last WRITE goes directly to DONE.

Decomposition:
- Package uart_prog_pkg holds:
  - the state enum;
  - HDR_BYTES=2;
  - BYTES_PER_WORD=4;
  - the timeout counter width derived from TIMEOUT via $clog2(TIMEOUT+1).
- One sub-module, word_pack: the lane counter and 32-bit little-endian assembler, with clear, byte strobe, word_valid pulse and word output.
- The FSM, index counter and timeout counter stay in uart_prog_ctrl.

Test Plan:
- Reset check:
  - Stimulus: assert rst=0 mid-DATA.
  - Required: all outputs return to their reset values immediately (asynchronously), and the next start_i runs a clean upload.
- Two-word upload:
  - Stimulus: start_i, then bytes 02 00 78 56 34 12 EF BE AD DE.
  - Required: wen pulse at adr 0 with dat 0x12345678; wen pulse at adr 1 with dat 0xDEADBEEF; DONE one cycle with done=1 and cpu_rst_n=0; then cpu_rst_n=1 and busy=0.
- Zero count:
  - Stimulus: start_i, then header 00 00.
  - Required: no wen pulse; DONE one cycle after the second header byte; done=1.
- Oversize count:
  - Stimulus: header 01 80 (0x8001) with MAX_WORDS=32768.
  - Required: ERR, err_o=1, cpu_rst_n_o=0, upg_done_o=0, no wen pulse. A later start_i clears err_o.
- Timeout:
  - Stimulus: TIMEOUT=100; header 01 00 plus 2 data bytes, then silence.
  - Required: ERR exactly 100 cycles after the last byte; no wen pulse.
  - Also: a byte in cycle 99 avoids ERR.
- Checksum (CHECKSUM_EN defined):
  - Stimulus: header 01 00, data 01 02 03 04, checksum byte 04.
  - Required: write of 0x04030201, then DONE.
  - Same sequence with checksum byte 05 → ERR, with the write still performed.
